// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART packet receiver
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         PKT_BYTES     = 7;
    localparam int         ADDR_W        = 16;
    localparam int         DATA_W        = 32;

    typedef enum logic [2:0] {
        S_SYNC,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_CSUM,
        S_ISSUE
    } state_t;

endpackage

// File: rtl/uart_byte_strobe.sv
// rtl/uart_byte_strobe.sv - one-cycle strobe on the rising edge of the receiver's level valid
module uart_byte_strobe (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    output logic o_stb
);

    logic r_valid_d;

    // Resets high so a valid level already present at reset release is not seen as a new byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid_d <= 1'b1;
        end else begin
            r_valid_d <= i_valid;
        end
    end

    assign o_stb = i_valid & ~r_valid_d;

endmodule

// File: rtl/uart_pkt_rx.sv
// rtl/uart_pkt_rx.sv - frames sync/addr/data/xor-checksum packets into bus writes; UART_PKT_RX_TIMEOUT_EN adds an inter-byte timeout
module uart_pkt_rx
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic              o_err_csum,
    output logic              o_err_overrun,
    output logic              o_busy
);

    state_t              r_state;
    logic [7:0]          r_acc;
    logic [1:0]          r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_valid;
    logic                r_err_csum;
    logic                r_err_overrun;
    logic                w_stb;
    logic                w_timeout;

    uart_byte_strobe u_stb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_byte_valid),
        .o_stb   (w_stb)
    );

`ifdef UART_PKT_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_stb || r_state == S_SYNC || r_state == S_ISSUE) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CLKS));
`else
    // Feature compiled out: the comparison is constant false and only keeps the parameter referenced.
    assign w_timeout = (TIMEOUT_CLKS < 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_SYNC;
            r_acc         <= '0;
            r_idx         <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_valid    <= 1'b0;
            r_err_csum    <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_csum    <= 1'b0;
            r_err_overrun <= 1'b0;
            if (w_timeout) begin
                r_state <= S_SYNC;
            end else begin
                case (r_state)
                    S_SYNC: begin
                        if (w_stb && i_byte == SYNC_BYTE) begin
                            r_acc   <= '0;
                            r_state <= S_ADDR_HI;
                        end
                    end
                    S_ADDR_HI: begin
                        if (w_stb) begin
                            r_addr[15:8] <= i_byte;
                            r_acc        <= r_acc ^ i_byte;
                            r_state      <= S_ADDR_LO;
                        end
                    end
                    S_ADDR_LO: begin
                        if (w_stb) begin
                            r_addr[7:0] <= i_byte;
                            r_acc       <= r_acc ^ i_byte;
                            r_idx       <= '0;
                            r_state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_stb) begin
                            r_data[{r_idx, 3'b000} +: 8] <= i_byte;
                            r_acc <= r_acc ^ i_byte;
                            r_idx <= r_idx + 2'd1;
                            if (r_idx == 2'd3) begin
                                r_state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (w_stb) begin
                            // Outputs only change here, so the bus never sees a half-built packet.
                            if ((r_acc ^ i_byte) == 8'h00) begin
                                r_wr_addr  <= r_addr;
                                r_wr_data  <= r_data;
                                r_wr_valid <= 1'b1;
                                r_state    <= S_ISSUE;
                            end else begin
                                r_err_csum <= 1'b1;
                                r_state    <= S_SYNC;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (w_stb) begin
                            r_err_overrun <= 1'b1;
                        end
                        if (i_wr_ready) begin
                            r_wr_valid <= 1'b0;
                            r_state    <= S_SYNC;
                        end
                    end
                    default: begin
                        r_state <= S_SYNC;
                    end
                endcase
            end
        end
    end

    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_wr_valid    = r_wr_valid;
    assign o_err_csum    = r_err_csum;
    assign o_err_overrun = r_err_overrun;
    assign o_busy        = (r_state != S_SYNC);

endmodule

// File: tb/tb_uart_pkt_rx.sv
// tb/tb_uart_pkt_rx.sv - self-checking bench for uart_pkt_rx with a stream-level packet model
module tb_uart_pkt_rx;
    import uart_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [7:0]        i_byte = 8'h00;
    logic              i_byte_valid = 1'b0;
    logic              i_wr_ready = 1'b1;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_wr_valid;
    logic              o_err_csum;
    logic              o_err_overrun;
    logic              o_busy;

    always #5 i_clk = ~i_clk;

    uart_pkt_rx #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(64)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_byte        (i_byte),
        .i_byte_valid  (i_byte_valid),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_wr_valid    (o_wr_valid),
        .i_wr_ready    (i_wr_ready),
        .o_err_csum    (o_err_csum),
        .o_err_overrun (o_err_overrun),
        .o_busy        (o_busy)
    );

    localparam logic [47:0] PKT1 = 48'h1234_DEADBEEF;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [47:0] got[$];
    logic [47:0] exp_w[$];
    logic [7:0]  sent[$];
    int          n_csum = 0;
    int          n_ovr = 0;
    int          exp_csum = 0;
    bit          both = 1'b0;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_wr_valid && i_wr_ready) got.push_back({o_wr_addr, o_wr_data});
            if (o_err_csum) n_csum++;
            if (o_err_overrun) n_ovr++;
            if (o_err_csum && o_err_overrun) both = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        i_byte_valid = 1'b0;
        tick(1);
        i_byte       = b;
        i_byte_valid = 1'b1;
        tick(hold);
        sent.push_back(b);
    endtask

    task automatic send_pkt(input logic [15:0] a, input logic [31:0] d,
                            input logic [7:0] corrupt, input int hold);
        logic [7:0] b[PKT_BYTES];
        b[0] = a[15:8];
        b[1] = a[7:0];
        for (int k = 0; k < 4; k++) b[2 + k] = d[8 * k +: 8];
        b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ corrupt;
        send_byte(8'hA5, hold);
        for (int k = 0; k < PKT_BYTES; k++) send_byte(b[k], hold);
    endtask

    task automatic clear_obs();
        got.delete();
        sent.delete();
        exp_w.delete();
        n_csum = 0;
        n_ovr = 0;
        exp_csum = 0;
        both = 1'b0;
    endtask

    // Reference: scan the byte stream for sync, take the next 7 bytes as one packet, XOR of all 7 must be zero.
    task automatic model_stream();
        int i = 0;
        logic [7:0] x;
        while (i < sent.size()) begin
            if (sent[i] == 8'hA5 && i + PKT_BYTES < sent.size()) begin
                x = 8'h00;
                for (int k = 1; k <= PKT_BYTES; k++) x ^= sent[i + k];
                if (x == 8'h00)
                    exp_w.push_back({sent[i+1], sent[i+2], sent[i+6], sent[i+5], sent[i+4], sent[i+3]});
                else
                    exp_csum++;
                i += PKT_BYTES + 1;
            end else begin
                i++;
            end
        end
    endtask

    function automatic logic [47:0] first_got();
        return (got.size() > 0) ? got[0] : 48'hx;
    endfunction

    task automatic test_reset();
        logic [51:0] outs;
        i_rst = 1'b1; i_byte = 8'hA5; i_byte_valid = 1'b1;
        tick(3);
        outs = {o_wr_valid, o_err_csum, o_err_overrun, o_busy, o_wr_addr, o_wr_data};
        n_cmp++; if (outs !== 52'h0) begin n_bad++; $display("FAIL reset_outputs: got %h expected %h", outs, 52'h0); end
        i_rst = 1'b0;
        tick(5);
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL no_strobe_after_reset: busy got %b expected 0", o_busy); end
        clear_obs();
        send_byte(8'hA5, 2); send_byte(8'h12, 2); send_byte(8'h34, 2);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid_packet: got %b expected 1", o_busy); end
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_mid_reset: got %b expected 0", o_busy); end
        clear_obs();
        send_pkt(16'h1234, 32'hDEADBEEF, 8'h00, 2);
        tick(5);
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL reset_recover_count: got %0d expected 1", got.size()); end
        n_cmp++; if (first_got() !== PKT1) begin n_bad++; $display("FAIL reset_recover_write: got %h expected %h", first_got(), PKT1); end
    endtask

    task automatic test_good_packet();
        logic [7:0] pb[8] = '{8'hA5, 8'h12, 8'h34, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04};
        clear_obs();
        i_wr_ready = 1'b1;
        for (int k = 0; k < 7; k++) send_byte(pb[k], 2);
        i_byte_valid = 1'b0;
        tick(1);
        i_byte = pb[7]; i_byte_valid = 1'b1;
        n_cmp++; if (o_wr_valid !== 1'b0) begin n_bad++; $display("FAIL valid_in_strobe_cycle: got %b expected 0", o_wr_valid); end
        tick(1);
        n_cmp++; if (o_wr_valid !== 1'b1) begin n_bad++; $display("FAIL valid_latency: got %b expected 1", o_wr_valid); end
        tick(1);
        n_cmp++; if (o_wr_valid !== 1'b0) begin n_bad++; $display("FAIL valid_one_cycle: got %b expected 0", o_wr_valid); end
        tick(3);
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL good_count: got %0d expected 1", got.size()); end
        n_cmp++; if (first_got() !== PKT1) begin n_bad++; $display("FAIL good_write: got %h expected %h", first_got(), PKT1); end
        n_cmp++; if (n_csum + n_ovr !== 0) begin n_bad++; $display("FAIL good_no_errors: got %0d expected 0", n_csum + n_ovr); end
    endtask

    task automatic test_bad_csum();
        clear_obs();
        send_pkt(16'h1234, 32'hDEADBEEF, 8'h01, 2);
        tick(3);
        send_pkt(16'h1234, 32'hDEADBEEF, 8'h00, 3);
        tick(5);
        n_cmp++; if (n_csum !== 1) begin n_bad++; $display("FAIL csum_pulse_count: got %0d expected 1", n_csum); end
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL csum_write_count: got %0d expected 1", got.size()); end
        n_cmp++; if (first_got() !== PKT1) begin n_bad++; $display("FAIL csum_next_write: got %h expected %h", first_got(), PKT1); end
    endtask

    task automatic test_garbage();
        clear_obs();
        send_byte(8'h00, 2); send_byte(8'hFF, 2); send_byte(8'h3C, 2);
        send_pkt(16'h1234, 32'hDEADBEEF, 8'h00, 2);
        tick(5);
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL garbage_count: got %0d expected 1", got.size()); end
        n_cmp++; if (first_got() !== PKT1) begin n_bad++; $display("FAIL garbage_write: got %h expected %h", first_got(), PKT1); end
    endtask

    task automatic test_backpressure();
        logic [48:0] cap;
        bit stable = 1'b1;
        int waited = 0;
        clear_obs();
        i_wr_ready = 1'b0;
        send_pkt(16'h1234, 32'hDEADBEEF, 8'h00, 2);
        while (o_wr_valid !== 1'b1 && waited < 20) begin tick(1); waited++; end
        n_cmp++; if (o_wr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout: got %b expected 1", o_wr_valid); end
        cap = {o_wr_valid, o_wr_addr, o_wr_data};
        n_cmp++; if (cap !== {1'b1, PKT1}) begin n_bad++; $display("FAIL bp_payload: got %h expected %h", cap, {1'b1, PKT1}); end
        for (int c = 0; c < 20; c++) begin tick(1); if ({o_wr_valid, o_wr_addr, o_wr_data} !== cap) stable = 1'b0; end
        send_byte(8'h77, 3);
        for (int c = 0; c < 26; c++) begin tick(1); if ({o_wr_valid, o_wr_addr, o_wr_data} !== cap) stable = 1'b0; end
        n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL bp_hold_stable: got %b expected 1", stable); end
        n_cmp++; if (n_ovr !== 1) begin n_bad++; $display("FAIL bp_overrun_count: got %0d expected 1", n_ovr); end
        i_wr_ready = 1'b1;
        tick(3);
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL bp_accept_count: got %0d expected 1", got.size()); end
        n_cmp++; if (first_got() !== PKT1) begin n_bad++; $display("FAIL bp_accept_write: got %h expected %h", first_got(), PKT1); end
    endtask

    task automatic test_overrun_at_accept();
        clear_obs();
        i_wr_ready = 1'b0;
        send_pkt(16'h0BAD, 32'h0000CAFE, 8'h00, 2);
        tick(4);
        i_byte_valid = 1'b0;
        tick(1);
        i_byte = 8'hA5; i_byte_valid = 1'b1; i_wr_ready = 1'b1;
        tick(4);
        n_cmp++; if (n_ovr !== 1) begin n_bad++; $display("FAIL accept_overrun_count: got %0d expected 1", n_ovr); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL accept_byte_dropped: busy got %b expected 0", o_busy); end
        n_cmp++; if (first_got() !== 48'h0BAD_0000CAFE) begin n_bad++; $display("FAIL accept_write: got %h expected %h", first_got(), 48'h0BAD_0000CAFE); end
    endtask

    task automatic test_random();
        logic [7:0] g;
        logic [15:0] a;
        clear_obs();
        i_wr_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, int'($urandom_range(1, 4)));
            end
            a = 16'($urandom);
            if (p == 0) a[15:8] = 8'hA5;
            send_pkt(a, 32'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                     int'($urandom_range(1, 4)));
        end
        tick(5);
        model_stream();
        n_cmp++; if (got.size() !== exp_w.size()) begin n_bad++; $display("FAIL rand_write_count: got %0d expected %0d", got.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < got.size(); k++) begin
            n_cmp++; if (got[k] !== exp_w[k]) begin n_bad++; $display("FAIL rand_write_%0d: got %h expected %h", k, got[k], exp_w[k]); end
        end
        n_cmp++; if (n_csum !== exp_csum) begin n_bad++; $display("FAIL rand_csum_count: got %0d expected %0d", n_csum, exp_csum); end
        n_cmp++; if (n_ovr !== 0) begin n_bad++; $display("FAIL rand_overrun_count: got %0d expected 0", n_ovr); end
        n_cmp++; if (both !== 1'b0) begin n_bad++; $display("FAIL rand_both_pulses: got %b expected 0", both); end
    endtask

`ifdef UART_PKT_RX_TIMEOUT_EN
    task automatic test_timeout();
        clear_obs();
        send_byte(8'hA5, 2); send_byte(8'h12, 2);
        tick(100);
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: busy got %b expected 0", o_busy); end
        send_pkt(16'h1234, 32'hDEADBEEF, 8'h00, 2);
        tick(5);
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL timeout_count: got %0d expected 1", got.size()); end
        n_cmp++; if (first_got() !== PKT1) begin n_bad++; $display("FAIL timeout_write: got %h expected %h", first_got(), PKT1); end
        n_cmp++; if (n_csum + n_ovr !== 0) begin n_bad++; $display("FAIL timeout_no_errors: got %0d expected 0", n_csum + n_ovr); end
    endtask
`endif

    initial begin
        test_reset();
        test_good_packet();
        test_bad_csum();
        test_garbage();
        test_backpressure();
        test_overrun_at_accept();
        test_random();
`ifdef UART_PKT_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
